// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants and FSM encoding for the NN input sequencer
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
  localparam logic signed [DATA_W-1:0] ONE_VAL = 16'sh0400;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } seq_state_t;

endpackage

// File: rtl/nn_input_sequencer_if.sv
// rtl/nn_input_sequencer_if.sv - switch input and NN core input bundle
interface nn_input_sequencer_if
  import nn_pkg::*;
#(
  parameter int W = DATA_W
);

  logic [2:0]          sw;
  logic signed [W-1:0] input_k_1;
  logic signed [W-1:0] input_k_2;
  logic                sample_valid;
  logic [1:0]          pattern_idx;
  logic                auto_mode;

  modport master (
    input  sw,
    output input_k_1, input_k_2, sample_valid, pattern_idx, auto_mode
  );

  modport slave (
    output sw,
    input  input_k_1, input_k_2, sample_valid, pattern_idx, auto_mode
  );

endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - 2-flop synchroniser plus whole-vector counter debounce
module sw_debounce #(
  parameter int W            = 3,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [W-1:0]     sync_1;
  logic [W-1:0]     sync_2;
  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;

  // One counter for the whole vector: any bit moving restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 != cand) begin
        cand <= sync_2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_input_sequencer.sv
// rtl/nn_input_sequencer.sv - debounced switches to NN core input patterns
// Manual pattern from sw[1:0], or auto-cycling through all four while sw[2] is set.
module nn_input_sequencer #(
  parameter int                                 DATA_W       = nn_pkg::DATA_W,
  parameter int                                 DEBOUNCE_CYC = 50000,
  parameter int                                 HOLD_CYC     = 100000,
  parameter logic signed [nn_pkg::DATA_W-1:0]   ONE_VAL      = nn_pkg::ONE_VAL
) (
  input logic                  clk,
  input logic                  res,
  nn_input_sequencer_if.master bus
);

  import nn_pkg::*;

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC - 1);

  logic [2:0]               sw_stable;
  seq_state_t               state;
  logic [1:0]               idx;
  logic [1:0]               nxt_idx;
  logic [HOLD_W-1:0]        hold_cnt;
  logic signed [DATA_W-1:0] k_1;
  logic signed [DATA_W-1:0] k_2;
  logic                     valid;

  sw_debounce #(
    .W            (3),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sw_debounce (
    .clk    (clk),
    .rst_n  (res),
    .raw    (bus.sw),
    .stable (sw_stable)
  );

  // Mode change takes priority over hold expiry; entering auto keeps the current pattern.
  always_comb begin
    nxt_idx = idx;
    case (state)
      ST_MANUAL: nxt_idx = sw_stable[2] ? idx : sw_stable[1:0];
      ST_AUTO: begin
        if (!sw_stable[2]) begin
          nxt_idx = sw_stable[1:0];
        end else if (hold_cnt == HOLD_MAX) begin
          nxt_idx = idx + 2'd1;
        end
      end
      default: nxt_idx = idx;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= ST_MANUAL;
      hold_cnt <= '0;
      idx      <= '0;
      k_1      <= '0;
      k_2      <= '0;
      valid    <= 1'b0;
    end else begin
      idx   <= nxt_idx;
      k_1   <= nxt_idx[1] ? ONE_VAL : '0;
      k_2   <= nxt_idx[0] ? ONE_VAL : '0;
      valid <= (nxt_idx != idx);
      case (state)
        ST_MANUAL: begin
          hold_cnt <= '0;
          if (sw_stable[2]) state <= ST_AUTO;
        end
        ST_AUTO: begin
          if (!sw_stable[2]) begin
            state    <= ST_MANUAL;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_MAX) begin
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_MANUAL;
      endcase
    end
  end

  assign bus.input_k_1    = k_1;
  assign bus.input_k_2    = k_2;
  assign bus.sample_valid = valid;
  assign bus.pattern_idx  = idx;
  assign bus.auto_mode    = (state == ST_AUTO);

endmodule
